// File: rtl/mac_accumulator.sv
// Frame accumulator for the NPU MAC unit: sums unsigned products per frame into a
// saturating accumulator built from 4-bit carry-lookahead slices.
`timescale 1ns/1ps

module mac_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_sum,
  output logic       o_c
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | ((&w_p) & i_c);

  assign o_sum = w_p ^ w_c[3:0];
  assign o_c   = w_c[4];
endmodule

module mac_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              busy
);
  localparam int NSLICE = ACC_W / 4;

  if ((PROD_W > ACC_W) || ((ACC_W % 4) != 0)) begin : g_bad_param
    $error("mac_accumulator: PROD_W must be <= ACC_W and ACC_W a multiple of 4");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_out_acc;
  logic               r_out_ovf;
  logic [CNT_W-1:0]   r_out_cnt;
  logic               r_out_valid;

  logic               w_accept;
  logic [ACC_W-1:0]   w_addend;
  logic [ACC_W-1:0]   w_sum;
  logic [NSLICE:0]    w_carry;
  logic               w_sat;
  logic [ACC_W-1:0]   w_next_acc;
  logic [CNT_W-1:0]   w_cnt_inc;

  // in_ready depends only on the output register, so a pending result is never overwritten
  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  assign w_addend   = ACC_W'(in_prod);
  assign w_carry[0] = 1'b0;

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    mac_cla4 u_cla (
      .i_a   (r_acc[4*s +: 4]),
      .i_b   (w_addend[4*s +: 4]),
      .i_c   (w_carry[s]),
      .o_sum (w_sum[4*s +: 4]),
      .o_c   (w_carry[s+1])
    );
  end

  // Sticky overflow pins the accumulator at all-ones for the rest of the frame
  assign w_sat      = w_carry[NSLICE] | r_ovf;
  assign w_next_acc = w_sat ? '1 : w_sum;
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (in_last) begin
          r_out_acc   <= w_next_acc;
          r_out_ovf   <= w_sat;
          r_out_cnt   <= w_cnt_inc;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_ovf       <= 1'b0;
          r_cnt       <= '0;
          r_state     <= IDLE;
        end else begin
          r_acc       <= w_next_acc;
          r_ovf       <= w_sat;
          r_cnt       <= w_cnt_inc;
          r_state     <= ACCUM;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;
  assign out_cnt   = r_out_cnt;
  assign busy      = (r_state == ACCUM);
endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed and random frames against an integer-sum model.
`timescale 1ns/1ps

module tb_mac_accumulator;
  localparam int PROD_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 8;
  localparam longint unsigned ACC_MAX = 65535;
  localparam int unsigned     CNT_MAX = 255;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;
  logic [CNT_W-1:0]  out_cnt;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned m_sum   = 0;
  int unsigned     m_terms = 0;
  logic [ACC_W-1:0] e_acc;
  logic             e_ovf;
  logic [CNT_W-1:0] e_cnt;

  mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame total is the plain integer sum clamped to the accumulator range
  task automatic model_take(input logic [PROD_W-1:0] p, input logic l);
    m_sum += longint'(p);
    m_terms++;
    if (l) begin
      e_ovf   = (m_sum > ACC_MAX);
      e_acc   = e_ovf ? ACC_W'(ACC_MAX) : ACC_W'(m_sum);
      e_cnt   = (m_terms > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(m_terms);
      m_sum   = 0;
      m_terms = 0;
    end
  endtask

  task automatic model_clear();
    m_sum   = 0;
    m_terms = 0;
  endtask

  // Presents one beat, waits (bounded) for acceptance, returns 1 time unit after the accepting edge
  task automatic beat(input logic [PROD_W-1:0] p, input logic l);
    int unsigned waited = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("beat_in_ready", in_ready, 1'b1);
    @(posedge clk);
    model_take(p, l);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_prod  = PROD_W'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".acc"},   out_acc,   e_acc);
    check({tag, ".ovf"},   out_ovf,   e_ovf);
    check({tag, ".cnt"},   out_cnt,   e_cnt);
    check({tag, ".busy"},  busy,      1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".valid"},    out_valid, 1'b0);
    check({tag, ".acc"},      out_acc,   '0);
    check({tag, ".ovf"},      out_ovf,   1'b0);
    check({tag, ".cnt"},      out_cnt,   '0);
    check({tag, ".busy"},     busy,      1'b0);
    check({tag, ".in_ready"}, in_ready,  1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PROD_W-1:0] p;
    int unsigned len;
    int unsigned k;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    check_zero_outputs("reset_init");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Mid-frame reset discards the partial sum
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b0);
    check("midframe.busy_before", busy, 1'b1);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_midframe");
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;

    beat(8'd5, 1'b0);
    check("f5_7.busy_mid", busy, 1'b1);
    beat(8'd7, 1'b1);
    check_result("f5_7");
    idle(1);
    check("f5_7.valid_drop", out_valid, 1'b0);

    beat(8'h0F, 1'b0);
    beat(8'h01, 1'b0);
    beat(8'hF0, 1'b1);
    check_result("carry");
    idle(1);

    for (int i = 0; i < 258; i++) beat(8'hFF, (i == 257));
    check_result("saturate");
    beat(8'd3, 1'b1);
    check_result("after_sat");
    idle(1);

    out_ready = 1'b0;
    beat(8'd10, 1'b1);
    check_result("bp_frame");
    in_valid = 1'b1;
    in_prod  = 8'd99;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp.in_ready", in_ready,  1'b0);
      check("bp.valid",    out_valid, 1'b1);
      check("bp.acc",      out_acc,   16'd10);
      check("bp.busy",     busy,      1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    model_take(8'd99, 1'b0);
    #1;
    check("bp.released_valid", out_valid, 1'b0);
    check("bp.released_busy",  busy,      1'b1);
    beat(8'd1, 1'b1);
    check_result("bp_next");
    idle(1);

    beat(8'd1, 1'b1);
    check_result("b2b_1");
    beat(8'd2, 1'b1);
    check_result("b2b_2");
    beat(8'd3, 1'b1);
    check_result("b2b_3");
    idle(1);
    check("b2b.valid_drop", out_valid, 1'b0);

    for (int i = 0; i < 300; i++) begin
      beat(8'd0, (i == 299));
      if (i != 299) begin
        check("cntsat.busy", busy, 1'b1);
        if ($urandom_range(0, 2) == 0) begin
          idle($urandom_range(1, 3));
          check("cntsat.busy_bubble", busy, 1'b1);
        end
      end
    end
    check_result("cntsat");
    idle(1);
    check("cntsat.busy_after", busy, 1'b0);

    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 6);
      for (int unsigned j = 0; j < len; j++) begin
        p = PROD_W'($urandom);
        beat(p, (j == len - 1));
        if (j != len - 1) begin
          check("rnd.busy", busy, 1'b1);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
      end
      check_result("rnd");
      in_valid = 1'b0;
      in_last  = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b0;
        k = $urandom_range(1, 3);
        for (int unsigned s = 0; s < k; s++) begin
          @(negedge clk);
          check("rnd.stall_valid",    out_valid, 1'b1);
          check("rnd.stall_acc",      out_acc,   e_acc);
          check("rnd.stall_in_ready", in_ready,  1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rnd.stall_drop", out_valid, 1'b0);
      end else begin
        idle(1);
      end
    end

    // Reset while a result is stalled must reopen in_ready at once
    out_ready = 1'b0;
    beat(8'd7, 1'b1);
    check_result("stall_frame");
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("stall.in_ready_low", in_ready, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_stalled");
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    beat(8'd4, 1'b1);
    check_result("post_reset");
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Accumulation stage of the NPU MAC unit, directly downstream of the multiplier/adder datapath. Accepts a stream of unsigned partial products over a valid/ready handshake, sums each frame (terminated by `in_last`) into a saturating accumulator, and presents the frame total with an overflow flag and term count on a registered valid/ready output. The accumulator adder is a chain of 4-bit carry-lookahead slices, rippling carry between slices.

## Interface
- `PROD_W`, default 8: product width, unsigned; must be ≤ `ACC_W`.
- `ACC_W`, default 16: accumulator width; must be a multiple of 4.
- `CNT_W`, default 8: term-counter width.

Ports:
- `clk`  in  1: clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: product beat valid.
- `in_ready`  out  1: stage can accept a beat.
- `in_prod`  in  `PROD_W`: unsigned product, zero-extended to `ACC_W`.
- `in_last`  in  1: beat is the final term of the frame.
- `out_valid`  out  1: frame result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_acc`  out  `ACC_W`: frame sum, saturated.
- `out_ovf`  out  1: the frame saturated.
- `out_cnt`  out  `CNT_W`: number of terms in the frame, saturating at all-ones.
- `busy`  out  1: a frame is partially accumulated.

## Operation
- Internal state: `acc` (`ACC_W`), `ovf` (sticky), `cnt` (`CNT_W`), output register {`out_acc`, `out_ovf`, `out_cnt`, `out_valid`}.
- FSM states:
  - IDLE: `acc`=0, `cnt`=0, `ovf`=0.
  - ACCUM: at least one non-last beat taken.
  - IDLE→ACCUM on an accepted non-last beat. ACCUM→IDLE on an accepted last beat. An accepted last beat in IDLE stays in IDLE (single-term frame).
- `busy` = (state == ACCUM).
- Beat accepted when `in_valid & in_ready`.
- `in_ready` = `~out_valid | out_ready`. It applies to all beats, so a result is never overwritten.
- Sum computation:
  - `sum = acc + zext(in_prod)` via `ACC_W/4` lookahead slices; carry-in of slice 0 is 0.
  - Carry-out of the top slice, or `ovf` already set, means saturate: the next value is all-ones and the overflow flag is 1.
  - Once saturated, `acc` stays all-ones for the rest of the frame.
- Accepted non-last beat: `acc`←next, `ovf`←next flag, `cnt`←`cnt`+1 (saturating).
- Accepted last beat:
  - Output register loads next sum, next flag, and `cnt`+1 (saturating).
  - `out_valid`←1.
  - `acc`, `ovf`, `cnt` clear to 0 on the same edge.
- Output handshake: `out_valid` drops on `out_valid & out_ready` unless a new last beat is accepted in that same cycle. In that case the output reloads and `out_valid` stays 1.
- `in_valid`=0 cycles are bubbles: no state change.
- Reset, asynchronous and possibly mid-frame: the partial frame is discarded. All state and all outputs go to 0, except `in_ready`, which becomes 1 combinationally.

## Timing
- Reset values: `out_valid`=0, `out_acc`=0, `out_ovf`=0, `out_cnt`=0, `busy`=0, `in_ready`=1.
- Latency: one cycle. A last beat accepted at edge N gives `out_valid`=1 after edge N; the result is visible from cycle N+1.
- Throughput: one beat per cycle. Back-to-back single-term frames sustain one result per cycle while `out_ready`=1.
- Backpressure: with `out_valid`=1 and `out_ready`=0, `in_ready`=0 and accumulation stalls. The output holds stable until accepted.
- `in_ready` is combinational from `out_valid` and `out_ready` only. No combinational path from `in_*` to `out_*`.
- The adder path is combinational within one cycle: ripple across `ACC_W/4` slices.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame after 3 beats → all outputs 0 and `in_ready`=1. Release, then send frame {5, 7 last} → `out_acc`=12, `out_cnt`=2, `out_ovf`=0 one cycle after the last beat.
- **Carry across slices:** frame {0x0F, 0x01, 0xF0 last}, 16-bit → `out_acc`=0x0100, `out_cnt`=3. This exercises the carry chain from slice 0 into slice 2.
- **Saturation:** 258 beats of 0xFF (last on the 258th) → true sum 65790 exceeds 65535, so `out_acc`=0xFFFF and `out_ovf`=1. The following frame {3 last} → `out_acc`=3, `out_ovf`=0.
- **Backpressure:**
  - Frame {10 last} with `out_ready`=0 for 4 cycles → `out_valid` held, `out_acc`=10 stable, `in_ready`=0.
  - Beats presented meanwhile are not consumed.
  - Raise `out_ready` → result taken and the next frame proceeds.
- **Back-to-back single-term frames:** {1 last}, {2 last}, {3 last} on consecutive cycles with `out_ready`=1 → `out_acc` 1, 2, 3 on consecutive cycles, `out_valid` continuously 1, `out_cnt`=1 each.
- **Counter saturation and bubbles:** `CNT_W`=8; 300 beats of 0 with random `in_valid` gaps → `out_cnt`=255, `out_acc`=0, `busy`=1 throughout, then 0 after the last beat.
